// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - RV32I LOAD/OP-IMM/STORE/BRANCH instruction encoder with output FIFO
//
// Purpose
//    Packs register fields, funct3 and a 32-bit immediate into a 32-bit RV32I
//    instruction word for the LOAD, OP-IMM, STORE and BRANCH formats. Encoding
//    is combinational on the request; the encoded word is written into a small
//    output FIFO on acceptance and appears at the FIFO head one cycle later.
//    Out-of-range immediates are truncated to the low bits the format uses;
//    the instruction is still emitted.
//
// Configuration
//    IMM_ENC_RANGE_CHECK_EN  defined: immediate range checking, out_err and
//                            err_cnt are active.
//                            undefined: no check logic, out_err and err_cnt
//                            are tied to zero.
//
// Parameters
//    DEPTH      output FIFO entries (>= 2)
//    CNT_W      width of the saturating range-error counter
//
// Ports
//    clk        in   1      clock, rising edge
//    rst_n      in   1      synchronous active-low reset
//    in_valid   in   1      request valid
//    in_ready   out  1      block can accept a request (FIFO not full)
//    fmt        in   2      00 LOAD, 01 OP-IMM, 10 STORE, 11 BRANCH
//    rd         in   5      destination register (LOAD/OP-IMM only)
//    rs1        in   5      source register 1
//    rs2        in   5      source register 2 (STORE/BRANCH only)
//    funct3     in   3      funct3 field
//    imm        in   32     signed immediate (byte offset for BRANCH)
//    out_valid  out  1      instruction valid (FIFO not empty)
//    out_ready  in   1      consumer accepts the instruction
//    instr      out  32     encoded instruction at the FIFO head
//    out_err    out  1      immediate of this instruction was out of range
//    err_cnt    out  CNT_W  saturating count of out-of-range requests accepted

module imm_encoder #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       fmt,
   input  logic [4:0]       rd,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   input  logic [2:0]       funct3,
   input  logic [31:0]      imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      instr,
   output logic             out_err,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_CNT  = CW'(1);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   // ------------------------------------------------------------------
   // Combinational encoder
   // ------------------------------------------------------------------
   logic [31:0] enc_instr;

   always_comb begin
      enc_instr = '0;
      case (fmt)
         2'b00:   enc_instr = {imm[11:0], rs1, funct3, rd, OP_LOAD};
         2'b01:   enc_instr = {imm[11:0], rs1, funct3, rd, OP_OPIMM};
         2'b10:   enc_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
         default: enc_instr = {imm[12], imm[10:5], rs2, rs1, funct3,
                               imm[4:1], imm[11], OP_BRANCH};
      endcase
   end

   // ------------------------------------------------------------------
   // FIFO control
   // ------------------------------------------------------------------
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr_nxt;
   logic [PW-1:0] rd_ptr_nxt;
   logic [CW-1:0] count;
   logic          push;
   logic          pop;
   logic          head_take_new;
   logic          head_take_mem;
   logic [31:0]   instr_mem [DEPTH];
   logic [31:0]   instr_q;

   // in_ready looks only at occupancy, so a full FIFO refuses a push even
   // when the head is being popped in the same cycle.
   assign in_ready  = (count < FULL_CNT);
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   assign wr_ptr_nxt = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
   assign rd_ptr_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;

   // The head is held in its own register so that instr/out_err keep the
   // last emitted value while the FIFO is empty. The new head is either the
   // word being pushed (FIFO empty, or its only entry leaving) or the next
   // stored entry (more than one entry and the head leaving).
   assign head_take_new = push & ((count == '0) | (pop & (count == ONE_CNT)));
   assign head_take_mem = pop & (count > ONE_CNT);

   always_ff @(posedge clk) begin
      if (push && rst_n) begin
         instr_mem[wr_ptr] <= enc_instr;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         instr_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr_nxt;
         end
         if (pop) begin
            rd_ptr <= rd_ptr_nxt;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (head_take_new) begin
            instr_q <= enc_instr;
         end else if (head_take_mem) begin
            instr_q <= instr_mem[rd_ptr_nxt];
         end
      end
   end

   assign instr = instr_q;

   // ------------------------------------------------------------------
   // Immediate range checking
   // ------------------------------------------------------------------
`ifdef IMM_ENC_RANGE_CHECK_EN
   logic             enc_err;
   logic             i_s_in_range;
   logic             b_in_range;
   logic             err_mem [DEPTH];
   logic             err_q;
   logic [CNT_W-1:0] err_cnt_q;

   // I/S immediates are 12-bit signed: bits 31..11 must be a sign extension.
   // B offsets are 13-bit signed and even: bits 31..12 sign-extend, bit 0 is 0.
   assign i_s_in_range = (&imm[31:11]) | ~(|imm[31:11]);
   assign b_in_range   = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
   assign enc_err      = (fmt == 2'b11) ? ~b_in_range : ~i_s_in_range;

   always_ff @(posedge clk) begin
      if (push && rst_n) begin
         err_mem[wr_ptr] <= enc_err;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         if (head_take_new) begin
            err_q <= enc_err;
         end else if (head_take_mem) begin
            err_q <= err_mem[rd_ptr_nxt];
         end
         if (push && enc_err && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
         end
      end
   end

   assign out_err = err_q;
   assign err_cnt = err_cnt_q;
`else
   // Upper immediate bits only matter to the range check.
   logic unused_imm_hi;
   assign unused_imm_hi = ^imm[31:13];

   assign out_err = 1'b0;
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - self-checking bench for imm_encoder

module tb_imm_encoder;

   localparam int CNT_W   = 3;
   localparam int CNT_MAX = 7;
`ifdef IMM_ENC_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   typedef struct {
      logic [1:0]  fmt;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [31:0] imm;
      logic [31:0] exp_instr;
      logic        exp_err;
   } vec_t;

   typedef struct packed {
      logic [31:0] instr;
      logic        err;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       fmt;
   logic [4:0]       rd;
   logic [4:0]       rs1;
   logic [4:0]       rs2;
   logic [2:0]       funct3;
   logic [31:0]      imm;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      instr;
   logic             out_err;
   logic [CNT_W-1:0] err_cnt;

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   exp_cnt = 0;
   exp_t exp_cur;
   exp_t sb[$];
   int   pop_cycles[$];

   imm_encoder #(.DEPTH(2), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .fmt(fmt), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .imm(imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .instr(instr), .out_err(out_err), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   // Reference encoder: builds the word field by field.
   function automatic logic [31:0] model_enc(input logic [1:0] f, input logic [4:0] d,
                                            input logic [4:0] s1, input logic [4:0] s2,
                                            input logic [2:0] f3, input logic [31:0] im);
      logic [31:0] w;
      w = '0;
      w[14:12] = f3;
      w[19:15] = s1;
      case (f)
         2'b00: begin w[6:0] = 7'h03; w[11:7] = d; w[31:20] = im[11:0]; end
         2'b01: begin w[6:0] = 7'h13; w[11:7] = d; w[31:20] = im[11:0]; end
         2'b10: begin w[6:0] = 7'h23; w[11:7] = im[4:0]; w[24:20] = s2; w[31:25] = im[11:5]; end
         default: begin
            w[6:0] = 7'h63; w[7] = im[11]; w[11:8] = im[4:1];
            w[24:20] = s2; w[30:25] = im[10:5]; w[31] = im[12];
         end
      endcase
      return w;
   endfunction

   function automatic logic model_err(input logic [1:0] f, input logic [31:0] im);
      int s;
      s = $signed(im);
      if (f == 2'b11) return !(s >= -4096 && s <= 4095 && im[0] == 1'b0);
      return !(s >= -2048 && s <= 2047);
   endfunction

   function automatic vec_t mk_m(input logic [1:0] f, input logic [4:0] d, input logic [4:0] s1,
                                 input logic [4:0] s2, input logic [2:0] f3, input logic [31:0] im);
      vec_t v;
      v = '{f, d, s1, s2, f3, im, model_enc(f, d, s1, s2, f3, im), model_err(f, im)};
      return v;
   endfunction

   function automatic vec_t mk_h(input logic [1:0] f, input logic [4:0] d, input logic [4:0] s1,
                                 input logic [4:0] s2, input logic [2:0] f3, input logic [31:0] im,
                                 input logic [31:0] ei, input logic ee);
      vec_t v;
      v = '{f, d, s1, s2, f3, im, ei, ee};
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: expected word queued at push, compared at pop.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         sb.delete();
         exp_cnt = 0;
      end else begin
         if (out_valid && out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_errors++;
               $display("FAIL unexpected_output: got instr=%h err=%b expected nothing", instr, out_err);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if (instr !== e.instr || out_err !== e.err) begin
                  n_errors++;
                  $display("FAIL output_order: got instr=%h err=%b expected instr=%h err=%b",
                           instr, out_err, e.instr, e.err);
               end
               pop_cycles.push_back(cyc);
            end
         end
         if (in_valid && in_ready) begin
            sb.push_back(exp_cur);
            if (exp_cur.err && exp_cnt != CNT_MAX) exp_cnt++;
         end
      end
   end

   task automatic drive(input vec_t v);
      fmt = v.fmt; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; funct3 = v.f3; imm = v.imm;
      exp_cur = '{v.exp_instr, RC & v.exp_err};
   endtask

   // Holds the request until accepted; returns at posedge+1 after the push edge.
   task automatic send(input vec_t v, input int bound);
      bit acc;
      bit ok;
      drive(v);
      in_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         acc = in_ready && rst_n;
         @(posedge clk);
         #1;
         if (acc) begin
            ok = 1'b1;
            break;
         end
      end
      in_valid = 1'b0;
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL send_timeout: got no acceptance expected acceptance within %0d cycles", bound);
      end
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (sb.size() == 0 && !out_valid) begin
            done = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!done) begin
         n_errors++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   localparam int NV = 20;
   vec_t tbl [NV];
   vec_t va, vb, vc;
   logic [31:0] dec_imm;

   initial begin
      tbl[0]  = mk_h(2'b00, 5'd5, 5'd2, 5'd9, 3'b010, -4,   32'hFFC12283, 1'b0);
      tbl[1]  = mk_h(2'b10, 5'd7, 5'd1, 5'd3, 3'b010, 8,    32'h0030A423, 1'b0);
      tbl[2]  = mk_h(2'b11, 5'd0, 5'd1, 5'd2, 3'b000, -8,   32'hFE208CE3, 1'b0);
      tbl[3]  = mk_h(2'b01, 5'd1, 5'd0, 5'd0, 3'b000, 2048, 32'h80000093, 1'b1);
      tbl[4]  = mk_h(2'b11, 5'd0, 5'd0, 5'd0, 3'b000, 3,    32'h00000163, 1'b1);
      tbl[5]  = mk_m(2'b01, 5'd3, 5'd4, 5'd0, 3'b111, 2047);
      tbl[6]  = mk_m(2'b01, 5'd3, 5'd4, 5'd0, 3'b100, -2048);
      tbl[7]  = mk_m(2'b01, 5'd3, 5'd4, 5'd0, 3'b001, -2049);
      tbl[8]  = mk_m(2'b10, 5'd31, 5'd6, 5'd7, 3'b000, -1);
      tbl[9]  = mk_m(2'b10, 5'd0, 5'd6, 5'd7, 3'b001, 2047);
      tbl[10] = mk_m(2'b10, 5'd0, 5'd6, 5'd7, 3'b010, -2049);
      tbl[11] = mk_m(2'b11, 5'd0, 5'd8, 5'd9, 3'b001, 4094);
      tbl[12] = mk_m(2'b11, 5'd0, 5'd8, 5'd9, 3'b100, -4096);
      tbl[13] = mk_m(2'b11, 5'd0, 5'd8, 5'd9, 3'b101, 4096);
      tbl[14] = mk_m(2'b00, 5'd10, 5'd11, 5'd0, 3'b000, 32'h7FFFFFFF);
      tbl[15] = mk_m(2'b00, 5'd12, 5'd13, 5'd0, 3'b100, 32'h80000000);
      for (int i = 16; i < NV; i++) begin
         tbl[i] = mk_m(2'($urandom_range(0, 3)), 5'($urandom), 5'($urandom), 5'($urandom),
                       3'($urandom), 32'($urandom_range(0, 8191)) - 32'd4096);
      end

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      fmt = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; imm = '0;
      exp_cur = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_in_ready",  32'(in_ready),  32'd1);
      chk("reset_instr",     instr,          32'd0);
      chk("reset_out_err",   32'(out_err),   32'd0);
      chk("reset_err_cnt",   32'(err_cnt),   32'd0);

      // Table vectors, one at a time with the consumer always ready.
      out_ready = 1'b1;
      for (int k = 0; k < NV; k++) begin
         if (k == 0) chk("no_bypass_valid", 32'(out_valid), 32'd0);
         send(tbl[k], 10);
         chk($sformatf("lat_valid_%0d", k), 32'(out_valid), 32'd1);
         chk($sformatf("instr_%0d", k), instr, tbl[k].exp_instr);
         chk($sformatf("err_%0d", k), 32'(out_err), 32'(RC & tbl[k].exp_err));
         chk($sformatf("err_cnt_%0d", k), 32'(err_cnt), 32'(exp_cnt));
         if (k == 2) begin
            dec_imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            chk("branch_roundtrip", dec_imm, 32'hFFFFFFF8);
         end
         if (k == 3) chk("err_cnt_after_opimm", 32'(err_cnt), RC ? 32'd1 : 32'd0);
         if (k == 4) chk("err_cnt_after_branch", 32'(err_cnt), RC ? 32'd2 : 32'd0);
      end
      drain();

      // Back-pressure: A,B fill the FIFO, C waits, then all drain in order.
      va = mk_m(2'b00, 5'd1, 5'd2, 5'd3, 3'b010, 100);
      vb = mk_m(2'b10, 5'd4, 5'd5, 5'd6, 3'b001, -300);
      vc = mk_m(2'b11, 5'd7, 5'd8, 5'd9, 3'b110, 5000);
      out_ready = 1'b0;
      send(va, 10);
      send(vb, 10);
      fork
         send(vc, 20);
         begin
            repeat (3) begin
               @(negedge clk);
               chk("full_in_ready", 32'(in_ready), 32'd0);
               chk("stall_valid",   32'(out_valid), 32'd1);
               chk("stall_instr",   instr, va.exp_instr);
            end
            @(posedge clk);
            #1;
            pop_cycles.delete();
            out_ready = 1'b1;
         end
      join
      drain();
      chk("burst_pops", 32'(pop_cycles.size()), 32'd3);
      if (pop_cycles.size() == 3) begin
         chk("burst_consec_1", 32'(pop_cycles[1] - pop_cycles[0]), 32'd1);
         chk("burst_consec_2", 32'(pop_cycles[2] - pop_cycles[1]), 32'd1);
      end

      // Reset with two entries held.
      out_ready = 1'b0;
      send(tbl[3], 10);
      send(tbl[4], 10);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("mid_reset_out_valid", 32'(out_valid), 32'd0);
      chk("mid_reset_in_ready",  32'(in_ready),  32'd1);
      chk("mid_reset_err_cnt",   32'(err_cnt),   32'd0);
      chk("mid_reset_instr",     instr,          32'd0);

      // A request presented only during reset must not be taken.
      out_ready = 1'b1;
      drive(tbl[0]);
      in_valid = 1'b1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      in_valid = 1'b0;
      chk("reset_cycle_no_push", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("reset_cycle_no_push_2", 32'(out_valid), 32'd0);

      // First request after reset: one-cycle latency.
      send(tbl[1], 10);
      chk("post_reset_latency", 32'(out_valid), 32'd1);
      chk("post_reset_instr", instr, tbl[1].exp_instr);
      drain();

      // Error counter saturation.
      for (int i = 0; i < 9; i++) begin
         send(mk_m(2'b01, 5'd2, 5'd3, 5'd0, 3'b000, 4096), 10);
         chk($sformatf("sat_err_cnt_%0d", i), 32'(err_cnt),
             RC ? 32'((i + 1 > CNT_MAX) ? CNT_MAX : i + 1) : 32'd0);
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
